// File: rtl/gr13_fir_pkg.sv
// Shared definitions for the gr13 FIR filter and its output buffering.
package gr13_fir_pkg;

   localparam int DATA_W = 11;
   localparam int NTAPS  = 11;
   localparam int COEF_W = NTAPS * DATA_W;

   typedef logic [DATA_W-1:0] sample_t;
   typedef logic [COEF_W-1:0] coef_bus_t;

   // Pointer width for a power-of-two FIFO depth.
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/gr13_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module gr13_fifo_mem
   import gr13_fir_pkg::*;
#(
   parameter int DW    = DATA_W,
   parameter int DEPTH = 16,
   parameter int AW    = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Write the incoming sample into its slot.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/gr13_fir_out_fifo.sv
// Output buffer behind the gr13 FIR: absorbs the backpressure-free sample
// stream and re-presents it first-word-fall-through over valid/ready.
// Samples arriving while full (and not being popped) are dropped and counted.
module gr13_fir_out_fifo
   import gr13_fir_pkg::*;
#(
   parameter int DW    = DATA_W,
   parameter int DEPTH = 16,
   parameter int AW    = ptr_width(DEPTH),
   parameter int CW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din,
   input  logic          vin,
   output logic [DW-1:0] dout,
   output logic          vout,
   input  logic          ready,
   output logic [AW:0]   count,
   output logic          full,
   output logic          ovf,
   output logic [CW-1:0] drops,
   input  logic          clr_ovf
);

   localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] DROPS_MAX = '1;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [DW-1:0] rdata;
   logic          push;
   logic          pop;
   logic          drop;

   assign full = (count == CNT_FULL);
   assign vout = (count != '0);
   assign pop  = vout & ready;
   // A pop on the same edge frees a slot, so a full FIFO can still accept.
   assign push = vin & (~full | pop);
   assign drop = vin & full & ~pop;
   // Head is read combinationally; forced to zero so idle output is quiet.
   assign dout = vout ? rdata : '0;

   gr13_fifo_mem #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag and saturating drop counter; a drop beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf   <= 1'b0;
         drops <= '0;
      end else if (drop) begin
         ovf <= 1'b1;
         if (clr_ovf) begin
            drops <= CW'(1);
         end else if (drops != DROPS_MAX) begin
            drops <= drops + 1'b1;
         end
      end else if (clr_ovf) begin
         ovf   <= 1'b0;
         drops <= '0;
      end
   end

endmodule

// File: tb/tb_gr13_fir_out_fifo.sv
// Directed bench for gr13_fir_out_fifo: a vector table for per-cycle
// behaviour plus hand sequences for reset handling.
module tb_gr13_fir_out_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] din;
   logic        vin;
   logic [10:0] dout;
   logic        vout;
   logic        ready;
   logic [4:0]  count;
   logic        full;
   logic        ovf;
   logic [7:0]  drops;
   logic        clr_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          grp;
      logic        vin;
      logic [10:0] din;
      logic        ready;
      logic        clr;
      logic        exp_vout;
      logic [10:0] exp_dout;
      logic [4:0]  exp_count;
      logic        exp_full;
      logic        exp_ovf;
      logic [7:0]  exp_drops;
   } vec_t;

   vec_t vecs[$];

   gr13_fir_out_fifo dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (din),
      .vin     (vin),
      .dout    (dout),
      .vout    (vout),
      .ready   (ready),
      .count   (count),
      .full    (full),
      .ovf     (ovf),
      .drops   (drops),
      .clr_ovf (clr_ovf)
   );

   always #5 clk = ~clk;

   function automatic void add(input int grp, input int v_in, input int d_in,
                               input int rdy, input int clr, input int e_vout,
                               input int e_dout, input int e_cnt, input int e_full,
                               input int e_ovf, input int e_drops);
      vec_t v;
      v.grp       = grp;
      v.vin       = 1'(v_in);
      v.din       = 11'(d_in);
      v.ready     = 1'(rdy);
      v.clr       = 1'(clr);
      v.exp_vout  = 1'(e_vout);
      v.exp_dout  = 11'(e_dout);
      v.exp_count = 5'(e_cnt);
      v.exp_full  = 1'(e_full);
      v.exp_ovf   = 1'(e_ovf);
      v.exp_drops = 8'(e_drops);
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s #%0d: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int idx, input logic e_vout,
                          input logic [10:0] e_dout, input logic [4:0] e_cnt,
                          input logic e_full, input logic e_ovf, input logic [7:0] e_drops);
      chk({tag, ".vout"},  idx, 32'(vout),  32'(e_vout));
      chk({tag, ".dout"},  idx, 32'(dout),  32'(e_dout));
      chk({tag, ".count"}, idx, 32'(count), 32'(e_cnt));
      chk({tag, ".full"},  idx, 32'(full),  32'(e_full));
      chk({tag, ".ovf"},   idx, 32'(ovf),   32'(e_ovf));
      chk({tag, ".drops"}, idx, 32'(drops), 32'(e_drops));
   endtask

   task automatic apply(input vec_t v, input int idx);
      vin     = v.vin;
      din     = v.din;
      ready   = v.ready;
      clr_ovf = v.clr;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec_g%0d", v.grp), idx, v.exp_vout, v.exp_dout,
              v.exp_count, v.exp_full, v.exp_ovf, v.exp_drops);
   endtask

   initial begin
      // Pass-through: each sample is at the head one cycle after its push.
      for (int k = 1; k <= 20; k++) add(2, 1, k, 1, 0, 1, k, 1, 0, 0, 0);
      add(2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(2, 0, 11'h123, 1, 0, 0, 0, 0, 0, 0, 0);
      // Fill with READY low, head stays stable, then drain in order.
      for (int i = 0; i < 16; i++) add(3, 1, -1024 + i, 0, 0, 1, -1024, i + 1, (i == 15) ? 1 : 0, 0, 0);
      for (int j = 0; j < 16; j++) add(3, 0, 0, 1, 0, (j < 15) ? 1 : 0, (j < 15) ? -1023 + j : 0, 15 - j, 0, 0, 0);
      // Refill, overflow three times, clear racing a drop, clear.
      for (int i = 0; i < 16; i++) add(4, 1, -1024 + i, 0, 0, 1, -1024, i + 1, (i == 15) ? 1 : 0, 0, 0);
      for (int m = 0; m < 3; m++) add(4, 1, 11'h055 + m, 0, 0, 1, -1024, 16, 1, 1, m + 1);
      add(4, 1, 11'h007, 0, 1, 1, -1024, 16, 1, 1, 1);
      add(4, 0, 0, 0, 1, 1, -1024, 16, 1, 0, 0);
      // Drop counter saturation.
      for (int m = 0; m < 258; m++) add(7, 1, 11'h2AA, 0, 0, 1, -1024, 16, 1, 1, (m + 1 > 255) ? 255 : m + 1);
      add(7, 0, 0, 0, 1, 1, -1024, 16, 1, 0, 0);
      // Full with simultaneous push and pop, then drain to see 0x3FF last.
      add(5, 1, 11'h3FF, 1, 0, 1, -1023, 16, 1, 0, 0);
      for (int j = 0; j < 16; j++)
         add(5, 0, 0, 1, 0, (j < 15) ? 1 : 0, (j < 14) ? -1022 + j : ((j == 14) ? 11'h3FF : 0), 15 - j, 0, 0, 0);
      // Partial fill for the mid-stream reset.
      for (int i = 0; i < 7; i++) add(6, 1, 11'h100 + i, 0, 0, 1, 11'h100, i + 1, 0, 0, 0);

      // Reset held with random inputs.
      rst_n   = 1'b0;
      clr_ovf = 1'b0;
      ready   = 1'b0;
      vin     = 1'b0;
      din     = '0;
      for (int c = 0; c < 5; c++) begin
         vin   = 1'($urandom);
         din   = 11'($urandom);
         ready = 1'($urandom);
         @(posedge clk);
         #1;
         chk_all("reset", c, 1'b0, 11'h000, 5'd0, 1'b0, 1'b0, 8'd0);
      end
      vin   = 1'b0;
      ready = 1'b0;
      rst_n = 1'b1;

      for (int n = 0; n < vecs.size(); n++) apply(vecs[n], n);

      // Asynchronous reset between edges with COUNT=7.
      chk("pre_rst.count", 0, 32'(count), 32'd7);
      vin = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 1'b0, 11'h000, 5'd0, 1'b0, 1'b0, 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #2;
      vin   = 1'b1;
      din   = 11'h155;
      ready = 1'b0;
      @(posedge clk);
      #1;
      chk_all("post_rst", 0, 1'b1, 11'h155, 5'd1, 1'b0, 1'b0, 8'd0);
      din   = 11'h2AA;
      ready = 1'b1;
      @(posedge clk);
      #1;
      chk_all("post_rst", 1, 1'b1, 11'h2AA, 5'd1, 1'b0, 1'b0, 8'd0);
      vin = 1'b0;
      @(posedge clk);
      #1;
      chk_all("post_rst", 2, 1'b0, 11'h000, 5'd0, 1'b0, 1'b0, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
